// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam int DIV_CYCLES = 32;

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_MULT = 2'b01;
  localparam logic [1:0] HILO_DIV  = 2'b10;

  localparam logic [1:0] MF_NONE = 2'b00;
  localparam logic [1:0] MF_LO   = 2'b01;
  localparam logic [1:0] MF_HI   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } divState_e;

endpackage

// File: rtl/mdu_hilo_div_radix2.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per step,
// dividend bits shift out of the quotient register into the partial remainder.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH:0]   partial_s;
  logic [WIDTH:0]   trial_s;

  // Trial subtraction; bit WIDTH of the result is the borrow
  always_comb begin
    partial_s = {rem_r, quot_r[WIDTH-1]};
    trial_s   = partial_s - {1'b0, divisor_r};
  end

  // Operand load on start, one shift-subtract per step
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_r    <= '0;
      rem_r     <= '0;
      divisor_r <= '0;
    end else if (start) begin
      quot_r    <= dividend;
      rem_r     <= '0;
      divisor_r <= divisor;
    end else if (step) begin
      if (trial_s[WIDTH] == 1'b0) begin
        rem_r  <= trial_s[WIDTH-1:0];
        quot_r <= {quot_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r  <= partial_s[WIDTH-1:0];
        quot_r <= {quot_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quot_r;
  assign remainder = rem_r;

endmodule

// File: rtl/mdu_hilo.sv
// Execute-stage multiply/divide unit owning HI/LO: single-cycle multiply,
// iterative divide with pipeline stall, move-to and move-from access.
module mdu_hilo #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = mdu_pkg::DIV_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       hilo_enE,
  input  logic [1:0]       hilo_mfE,
  input  logic [1:0]       hilo_wtE,
  input  logic             hassignE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic [WIDTH-1:0] hilo_rdataE,
  output logic             stallE,
  output logic             busy
);

  import mdu_pkg::*;

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_CYCLES - 1);

  divState_e          state_r;
  logic [CNT_W-1:0]   count_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               quotNeg_r;
  logic               remNeg_r;
  logic               divZero_r;

  logic [2*WIDTH-1:0] extA_s;
  logic [2*WIDTH-1:0] extB_s;
  logic [2*WIDTH-1:0] product_s;
  logic [WIDTH-1:0]   magA_s;
  logic [WIDTH-1:0]   magB_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   divQuot_s;
  logic [WIDTH-1:0]   divRem_s;
  logic               divStart_s;
  logic               divStep_s;

  // Operand conditioning: sign/zero extension for the product, magnitudes for the divider
  always_comb begin
    extA_s    = {{WIDTH{hassignE & srcaE[WIDTH-1]}}, srcaE};
    extB_s    = {{WIDTH{hassignE & srcbE[WIDTH-1]}}, srcbE};
    product_s = extA_s * extB_s;
    if (hassignE && srcaE[WIDTH-1]) begin
      magA_s = -srcaE;
    end else begin
      magA_s = srcaE;
    end
    if (hassignE && srcbE[WIDTH-1]) begin
      magB_s = -srcbE;
    end else begin
      magB_s = srcbE;
    end
    divStart_s = !rst && (state_r == IDLE) && (hilo_enE == HILO_DIV);
    divStep_s  = (state_r == BUSY);
  end

  div_radix2 #(.WIDTH(WIDTH)) uDiv (
    .clk       (clk),
    .rst       (rst),
    .start     (divStart_s),
    .step      (divStep_s),
    .dividend  (magA_s),
    .divisor   (magB_s),
    .quotient  (quot_s),
    .remainder (rem_s)
  );

  // Divide result with signs restored; a zero divisor always yields an all-ones quotient
  always_comb begin
    if (divZero_r) begin
      divQuot_s = '1;
    end else if (quotNeg_r) begin
      divQuot_s = -quot_s;
    end else begin
      divQuot_s = quot_s;
    end
    if (remNeg_r) begin
      divRem_s = -rem_s;
    end else begin
      divRem_s = rem_s;
    end
  end

  // Divide sequencing and HI/LO updates
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      count_r   <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      quotNeg_r <= 1'b0;
      remNeg_r  <= 1'b0;
      divZero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hilo_enE == HILO_MULT) begin
            {hi_r, lo_r} <= product_s;
          end else if (hilo_enE == HILO_DIV) begin
            quotNeg_r <= hassignE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            remNeg_r  <= hassignE & srcaE[WIDTH-1];
            divZero_r <= (srcbE == '0);
            count_r   <= '0;
            state_r   <= BUSY;
          end else if (hilo_enE == HILO_NONE) begin
            if (hilo_wtE[0]) lo_r <= srcaE;
            if (hilo_wtE[1]) hi_r <= srcaE;
          end
        end
        BUSY: begin
          if (count_r == LAST_ITER) begin
            state_r <= DONE;
          end else begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          hi_r    <= divRem_s;
          lo_r    <= divQuot_s;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Stall, observability and move-from read mux
  always_comb begin
    busy = (state_r != IDLE);
    if (rst) begin
      stallE      = 1'b0;
      hilo_rdataE = '0;
    end else begin
      stallE = (state_r == BUSY) || ((state_r == IDLE) && (hilo_enE == HILO_DIV));
      case (hilo_mfE)
        MF_LO:   hilo_rdataE = lo_r;
        MF_HI:   hilo_rdataE = hi_r;
        MF_NONE: hilo_rdataE = '0;
        default: hilo_rdataE = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed vector table, hand-written corner
// sequences and random operations against an arithmetic reference model.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  hilo_enE, hilo_mfE, hilo_wtE;
  logic        hassignE;
  logic [31:0] srcaE, srcbE;
  logic [31:0] hilo_rdataE;
  logic        stallE, busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  typedef struct {
    logic [1:0]  en;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    string       name;
  } vec_t;

  vec_t vecs[9];

  mdu_hilo #(.WIDTH(32), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .hilo_enE(hilo_enE), .hilo_mfE(hilo_mfE),
    .hilo_wtE(hilo_wtE), .hassignE(hassignE), .srcaE(srcaE), .srcbE(srcbE),
    .hilo_rdataE(hilo_rdataE), .stallE(stallE), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] refMul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  // Returns {remainder, quotient}
  function automatic logic [63:0] refDiv(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
    end
    return {x % y, x / y};
  endfunction

  // Read both registers through the move-from port and compare with the model
  task automatic checkHiLo(input string name);
    hilo_enE = HILO_NONE;
    hilo_wtE = 2'b00;
    hilo_mfE = MF_LO;
    #1;
    check({name, "_lo"}, hilo_rdataE, mLo);
    hilo_mfE = MF_HI;
    #1;
    check({name, "_hi"}, hilo_rdataE, mHi);
    check({name, "_stall"}, {31'd0, stallE}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    hilo_mfE = MF_NONE;
    step();
  endtask

  // Issue an operation, hold it while stalled, count stall cycles
  task automatic runOp(input logic [1:0] op, input logic s, input logic [31:0] x,
                       input logic [31:0] y, input string name);
    int stalls = 0;
    bit done = 1'b0;
    hilo_enE = op;
    hassignE = s;
    srcaE    = x;
    srcbE    = y;
    hilo_wtE = 2'b00;
    hilo_mfE = MF_NONE;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (stallE) begin
        stalls++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    check({name, "_stallcnt"}, 32'(stalls), (op == HILO_DIV) ? 32'd33 : 32'd0);
    step();
    hilo_enE = HILO_NONE;
  endtask

  initial begin
    logic [1:0]  kind;
    logic        s;
    logic [31:0] x, y;

    vecs[0] = '{HILO_MULT, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "smul"};
    vecs[1] = '{HILO_MULT, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, "umul"};
    vecs[2] = '{HILO_DIV,  1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "sdiv"};
    vecs[3] = '{HILO_DIV,  1'b0, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, "udivz"};
    vecs[4] = '{HILO_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "sdivovf"};
    vecs[5] = '{HILO_DIV,  1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF, "udivmsb"};
    vecs[6] = '{HILO_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "smulmin"};
    vecs[7] = '{HILO_DIV,  1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, "sdivneg"};
    vecs[8] = '{HILO_DIV,  1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "sdivz"};

    // Reset: outputs held low even with a divide request and move-to pending
    rst = 1'b1;
    hilo_enE = HILO_DIV;
    hilo_mfE = MF_HI;
    hilo_wtE = 2'b11;
    hassignE = 1'b0;
    srcaE = 32'hFFFF_FFFF;
    srcbE = 32'h0000_0001;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_stall", {31'd0, stallE}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rdata", hilo_rdataE, 32'd0);
    end
    rst = 1'b0;
    hilo_enE = HILO_NONE;
    hilo_wtE = 2'b00;
    checkHiLo("rst_regs");

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      runOp(vecs[i].en, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].name);
      mHi = vecs[i].expHi;
      mLo = vecs[i].expLo;
      checkHiLo(vecs[i].name);
    end

    // Reset at BUSY iteration 10 abandons the divide and clears HI/LO
    hilo_enE = HILO_DIV;
    hassignE = 1'b0;
    srcaE = 32'd1000;
    srcbE = 32'd3;
    step();
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    hilo_enE = HILO_NONE;
    #1;
    check("rstmid_stall", {31'd0, stallE}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    mHi = 32'd0;
    mLo = 32'd0;
    checkHiLo("rstmid");
    runOp(HILO_DIV, 1'b0, 32'd100, 32'd7, "div100_7");
    mHi = 32'd2;
    mLo = 32'd14;
    checkHiLo("div100_7");

    // Move-to each register, then move-to colliding with a multiply
    hilo_wtE = 2'b01;
    srcaE = 32'hA5A5_A5A5;
    step();
    hilo_wtE = 2'b10;
    srcaE = 32'h5A5A_5A5A;
    step();
    mLo = 32'hA5A5_A5A5;
    mHi = 32'h5A5A_5A5A;
    checkHiLo("mt");
    hilo_enE = HILO_MULT;
    hilo_wtE = 2'b11;
    hassignE = 1'b0;
    srcaE = 32'd3;
    srcbE = 32'd5;
    step();
    mHi = 32'd0;
    mLo = 32'd15;
    checkHiLo("mt_vs_mul");

    // Random operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      kind = 2'($urandom_range(0, 2));
      s    = 1'($urandom_range(0, 1));
      x    = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      else if ($urandom_range(0, 1) == 1) y = $urandom;
      else y = 32'($urandom_range(1, 300));
      if (kind == 2'd0) begin
        runOp(HILO_MULT, s, x, y, "rmul");
        {mHi, mLo} = refMul(x, y, s);
      end else if (kind == 2'd1) begin
        runOp(HILO_DIV, s, x, y, "rdiv");
        {mHi, mLo} = refDiv(x, y, s);
      end else begin
        hilo_wtE = 2'($urandom_range(1, 3));
        srcaE = x;
        step();
        if (hilo_wtE[0]) mLo = x;
        if (hilo_wtE[1]) mHi = x;
        hilo_wtE = 2'b00;
      end
      checkHiLo("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide responder for the execute stage. It consumes the controller's execute-stage multiply/divide controls (hilo_enE, hilo_mfE, hassignE) together with the two execute-stage operands.
- Owns the architectural HI/LO registers. Performs signed or unsigned multiply in a single cycle and divide iteratively over multiple cycles.
- Raises stallE to the hazard unit while a divide is in flight, and returns HI or LO for move-from instructions.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, the product is 2*WIDTH bits.
- DIV_CYCLES, 32, number of radix-2 iterations; must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- hilo_enE  in  2  operation select: 00 none, 01 multiply, 10 divide, 11 reserved (treated as none).
- hilo_mfE  in  2  move-from select: 00 none, 01 read LO, 10 read HI, 11 reserved (reads 0).
- hilo_wtE  in  2  move-to select: bit0 writes LO from srcaE, bit1 writes HI from srcaE.
- hassignE  in  1  1 = signed operation, 0 = unsigned.
- srcaE  in  WIDTH  rs operand (dividend / multiplicand / move-to data).
- srcbE  in  WIDTH  rt operand (divisor / multiplier).
- hilo_rdataE  out  WIDTH  combinational HI/LO read data for a move-from.
- stallE  out  1  divide in progress; the hazard unit freezes PC, IF, ID and EX while it is high.
- busy  out  1  state != IDLE; debug/observability only.

Behaviour:
- Reset, checked every edge with rst high:
  - HI and LO clear to 0; state goes to IDLE; iteration counter clears to 0.
  - stallE = 0, busy = 0, hilo_rdataE = 0.
  - Reset in the middle of a divide abandons it; HI/LO are not updated.
- Multiply (IDLE, hilo_enE = 01):
  - Full 2*WIDTH product, signed when hassignE = 1, otherwise unsigned.
  - {HI, LO} is written at the end of the same cycle. Latency is 1 and stallE is never raised.
- Move-to (IDLE, hilo_wtE != 0):
  - The selected register(s) load srcaE at the edge.
  - Ignored if hilo_enE != 00 in the same cycle, because the operation wins.
- Move-from: hilo_rdataE = LO when hilo_mfE = 01, HI when 10, 0 otherwise. It reads the registered HI/LO values, so a multiply in cycle t is visible to a move-from in cycle t+1.
- Divide state machine, states IDLE, BUSY and DONE:
  - IDLE with hilo_enE = 10:
    - Latch the operand magnitudes (absolute values when hassignE = 1), the quotient sign (sign(a) ^ sign(b)) and the remainder sign (sign(a)).
    - Load the counter with 0 and go to BUSY.
    - stallE = 1 combinationally in this issue cycle.
  - BUSY:
    - One restoring shift-subtract iteration per cycle, stallE = 1.
    - When the counter reaches DIV_CYCLES-1, go to DONE; otherwise increment the counter.
  - DONE:
    - Apply the signs and write HI = remainder, LO = quotient at the edge.
    - stallE = 0 so the divide instruction leaves EX.
    - hilo_enE is ignored in this cycle; this prevents re-issuing the same divide. Go to IDLE.
  - Total stall is DIV_CYCLES+1 = 33 cycles. Results are visible 34 cycles after issue.
- Divide boundary cases:
  - Divisor 0: full latency, quotient = all ones, remainder = dividend (raw srcaE).
  - Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0, which falls out of the magnitude arithmetic.
  - Unsigned operands with the MSB set use the full WIDTH-bit magnitude with no sign handling.
- Inputs other than rst are don't-care during BUSY, because the pipeline is frozen.
- Move-from/to are not accepted during BUSY/DONE.

Decomposition:
- Shared package mdu_pkg:
  - hilo_enE encodings: HILO_NONE, HILO_MULT, HILO_DIV.
  - hilo_mfE encodings: MF_NONE, MF_LO, MF_HI.
  - State enum: IDLE, BUSY, DONE.
  - DIV_CYCLES constant.
- One sub-module, div_radix2:
  - Iterative unsigned magnitude divider with start, step and quotient/remainder outputs.
  - mdu_hilo wraps it with the sign handling, HI/LO registers and stall logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> HI=LO=0, stallE=0; hilo_mfE=10 gives hilo_rdataE=0.
- Signed multiply: srcaE=0xFFFFFFFE (-2), srcbE=3, hassignE=1, en=01 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA, stallE never high. The same operands unsigned -> HI=0x00000002, LO=0xFFFFFFFA.
- Signed divide: srcaE=-7 (0xFFFFFFF9), srcbE=2, en=10 -> stallE high exactly 33 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); en held during the stall causes no second divide.
- Divide by zero: srcaE=0x12345678, srcbE=0, unsigned -> 33 stall cycles, then LO=0xFFFFFFFF, HI=0x12345678.
- Reset mid-divide: issue a divide, assert rst at BUSY iteration 10 -> the next cycle shows stallE=0, busy=0, HI=LO=0; a new divide of 100/7 afterwards gives LO=14, HI=2.
- Move-to/move-from: wt=01 with srcaE=0xA5A5A5A5, then wt=10 with srcaE=0x5A5A5A5A -> mf=01 reads 0xA5A5A5A5 and mf=10 reads 0x5A5A5A5A. Move-to together with en=01 in the same cycle -> the product wins.
